// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate decoder with pc+imm and valid/ready handshake
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } ent_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  ent_t       dec;

  assign opc = inst_code[6:0];
  assign f3  = inst_code[14:12];

  always_comb begin
    dec = '0;
    if (inst_code[1:0] != 2'b11) begin
      dec.ill = 1'b1;
    end else begin
      case (opc)
        7'b0010011: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            dec.typ = T_SHAMT;
            // arithmetic-right form is the only one allowed a non-zero upper field
            if (XLEN == 32) begin
              dec.imm = XLEN'(inst_code[24:20]);
              dec.ill = !(inst_code[31:25] == 7'b0000000 ||
                          (inst_code[31:25] == 7'b0100000 && f3 == 3'b101));
            end else begin
              dec.imm = XLEN'(inst_code[25:20]);
              dec.ill = !(inst_code[31:26] == 6'b000000 ||
                          (inst_code[31:26] == 6'b010000 && f3 == 3'b101));
            end
          end else begin
            dec.typ = T_I;
            dec.imm = sext32({{20{inst_code[31]}}, inst_code[31:20]});
          end
        end
        7'b0000011: begin
          dec.typ = T_I;
          dec.imm = sext32({{20{inst_code[31]}}, inst_code[31:20]});
        end
        7'b1100111: begin
          dec.typ = T_I;
          dec.imm = sext32({{20{inst_code[31]}}, inst_code[31:20]});
          dec.ill = (f3 != 3'b000);
        end
        7'b0100011: begin
          dec.typ = T_S;
          dec.imm = sext32({{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]});
        end
        7'b1100011: begin
          dec.typ = T_B;
          dec.imm = sext32({{19{inst_code[31]}}, inst_code[31], inst_code[7],
                            inst_code[30:25], inst_code[11:8], 1'b0});
          dec.ill = (f3 == 3'b010 || f3 == 3'b011);
        end
        7'b0110111, 7'b0010111: begin
          dec.typ = T_U;
          dec.imm = sext32({inst_code[31:12], 12'b0});
        end
        7'b1101111: begin
          dec.typ = T_J;
          dec.imm = sext32({{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                            inst_code[20], inst_code[30:21], 1'b0});
        end
        7'b0110011, 7'b0001111, 7'b1110011: begin
          dec.typ = T_NONE;
        end
        default: begin
          dec.ill = 1'b1;
        end
      endcase
    end
    dec.tgt = pc + dec.imm;
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_valid;
  ent_t              data_q  [STAGES];
  ent_t              data_d  [STAGES];
  ent_t              up_data [STAGES];

  // A stage can take new data if it is empty or everything downstream can move.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = r || !valid_q[k];
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] && !flush;

  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = dec;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (rdy[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k]) data_d[k] = up_data[k];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign imm_out   = data_q[STAGES-1].imm;
  assign imm_type  = data_q[STAGES-1].typ;
  assign target    = data_q[STAGES-1].tgt;
  assign illegal   = data_q[STAGES-1].ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (three configurations)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [31:0] k);
    logic [31:0] r;
    r = 32'h0000_0013;
    r[31:20] = k[11:0];
    return r;
  endfunction

  // a: XLEN=32 STAGES=1, b: XLEN=32 STAGES=3, c: XLEN=64 STAGES=2
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ill;
  logic [31:0] a_inst, a_pc, a_imm, a_tgt;
  logic [2:0]  a_type;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ill;
  logic [31:0] b_inst, b_pc, b_imm, b_tgt;
  logic [2:0]  b_type;
  logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ill;
  logic [31:0] c_inst;
  logic [63:0] c_pc, c_imm, c_tgt;
  logic [2:0]  c_type;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .reset(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .inst_code(a_inst), .pc(a_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm_out(a_imm), .imm_type(a_type), .target(a_tgt), .illegal(a_ill));

  imm_gen_pipe #(.XLEN(32), .STAGES(3)) u_b (
    .clk(clk), .reset(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .inst_code(b_inst), .pc(b_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm_out(b_imm), .imm_type(b_type), .target(b_tgt), .illegal(b_ill));

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_c (
    .clk(clk), .reset(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .inst_code(c_inst), .pc(c_pc), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .imm_out(c_imm), .imm_type(c_type), .target(c_tgt), .illegal(c_ill));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] tgt;
    logic        ill;
  } vec_t;

  vec_t va[16];
  vec_t vc[4];

  initial begin
    int sent, delivered, fr, e, inflight;
    int exp_q[$];
    logic prev_hold, saw_full;
    logic [31:0] prev_imm, prev_tgt;

    va[0]  = '{32'hFFF00093, 64'h0,    64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF, 1'b0};
    va[1]  = '{32'hFE000EE3, 64'h200,  64'hFFFFFFFC, 3'd3, 64'h1FC,      1'b0};
    va[2]  = '{32'h0080006F, 64'h100,  64'h8,        3'd5, 64'h108,      1'b0};
    va[3]  = '{32'h4030D093, 64'h10,   64'h3,        3'd6, 64'h13,       1'b0};
    va[4]  = '{32'h40109093, 64'h0,    64'h1,        3'd6, 64'h1,        1'b1};
    va[5]  = '{32'h00000000, 64'h44,   64'h0,        3'd0, 64'h44,       1'b1};
    va[6]  = '{32'h00112623, 64'h0,    64'hC,        3'd2, 64'hC,        1'b0};
    va[7]  = '{32'h12345037, 64'h8,    64'h12345000, 3'd4, 64'h12345008, 1'b0};
    va[8]  = '{32'h00009067, 64'h4,    64'h0,        3'd1, 64'h4,        1'b1};
    va[9]  = '{32'h002081B3, 64'h4,    64'h0,        3'd0, 64'h4,        1'b0};
    va[10] = '{32'h0000007F, 64'h0,    64'h0,        3'd0, 64'h0,        1'b1};
    va[11] = '{32'h00002063, 64'h0,    64'h0,        3'd3, 64'h0,        1'b1};
    va[12] = '{32'h4200D093, 64'h0,    64'h0,        3'd6, 64'h0,        1'b1};
    va[13] = '{32'hFFF02083, 64'h100,  64'hFFFFFFFF, 3'd1, 64'hFF,       1'b0};
    va[14] = '{32'hFFDFF0EF, 64'h10,   64'hFFFFFFFC, 3'd5, 64'hC,        1'b0};
    va[15] = '{32'hFFFFF017, 64'h2000, 64'hFFFFF000, 3'd4, 64'h1000,     1'b0};

    vc[0] = '{32'h800000B7, 64'h10, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000010, 1'b0};
    vc[1] = '{32'h03F09093, 64'h0,  64'h3F,               3'd6, 64'h3F,               1'b0};
    vc[2] = '{32'h4200D093, 64'h0,  64'h20,               3'd6, 64'h20,               1'b0};
    vc[3] = '{32'h40109093, 64'h0,  64'h1,                3'd6, 64'h1,                1'b1};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_inst = '0; a_pc = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_inst = '0; b_pc = '0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_inst = '0; c_pc = '0;
    tick();
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_imm",   a_imm, 0);
    check("rst_a_type",  a_type, 0);
    check("rst_a_tgt",   a_tgt, 0);
    check("rst_a_ill",   a_ill, 0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_c_valid", c_out_valid, 0);
    rst = 1'b0;
    tick();

    // single-stage decode table
    a_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1; a_inst = va[i].inst; a_pc = va[i].pc[31:0];
      tick();
      a_in_valid = 0;
      #1;
      check($sformatf("A%0d_valid", i), a_out_valid, 1);
      check($sformatf("A%0d_imm", i),   a_imm, va[i].imm);
      check($sformatf("A%0d_type", i),  a_type, va[i].typ);
      check($sformatf("A%0d_tgt", i),   a_tgt, va[i].tgt);
      check($sformatf("A%0d_ill", i),   a_ill, va[i].ill);
    end
    tick();

    // three-stage streaming: latency 3, no gaps
    b_out_ready = 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      b_in_valid = (cyc < 8);
      b_inst = addi(cyc + 1);
      b_pc = 32'h1000 + 4 * cyc;
      #1;
      check($sformatf("B%0d_valid", cyc), b_out_valid, (cyc >= 3 && cyc < 11));
      if (cyc < 8) check($sformatf("B%0d_in_ready", cyc), b_in_ready, 1);
      if (cyc >= 3 && cyc < 11) begin
        check($sformatf("B%0d_imm", cyc), b_imm, cyc - 2);
        check($sformatf("B%0d_tgt", cyc), b_tgt, 32'h1000 + 4 * (cyc - 3) + (cyc - 2));
      end
      tick();
    end

    // three-stage backpressure with scoreboard
    sent = 0; delivered = 0; fr = -1; prev_hold = 0; saw_full = 0;
    prev_imm = '0; prev_tgt = '0;
    b_out_ready = 0;
    for (int cyc = 0; cyc < 60 && delivered < 8; cyc++) begin
      b_in_valid = (sent < 8);
      b_inst = addi(sent + 20);
      b_pc = 32'h2000 + 4 * sent;
      #1;
      if (fr < 0 && b_out_valid) fr = cyc;
      b_out_ready = (fr >= 0) && (cyc >= fr + 5);
      #1;
      inflight = sent - delivered;
      check($sformatf("C%0d_in_ready", cyc), b_in_ready, !(inflight == 3 && !b_out_ready));
      if (!b_in_ready) saw_full = 1;
      if (prev_hold) begin
        check($sformatf("C%0d_hold_valid", cyc), b_out_valid, 1);
        check($sformatf("C%0d_hold_imm", cyc), b_imm, prev_imm);
        check($sformatf("C%0d_hold_tgt", cyc), b_tgt, prev_tgt);
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("C%0d_extra_out", cyc), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("C%0d_imm", cyc), b_imm, e + 20);
          check($sformatf("C%0d_tgt", cyc), b_tgt, 32'h2000 + 4 * e + e + 20);
        end
        delivered++;
      end
      prev_hold = b_out_valid && !b_out_ready;
      prev_imm = b_imm;
      prev_tgt = b_tgt;
      tick();
    end
    b_in_valid = 0;
    #1;
    check("C_delivered", delivered, 8);
    check("C_sent", sent, 8);
    check("C_saw_full", saw_full, 1);
    tick();
    check("C_drained", b_out_valid, 0);

    // two-stage flush with two entries in flight and a third offered
    c_out_ready = 0;
    c_in_valid = 1; c_inst = addi(5); c_pc = 64'h3000;
    tick();
    c_inst = addi(6); c_pc = 64'h3004;
    tick();
    c_inst = addi(7); c_pc = 64'h3008; c_flush = 1;
    #1;
    check("D_in_ready_flush", c_in_ready, 0);
    check("D_valid_preflush", c_out_valid, 1);
    tick();
    c_flush = 0; c_in_valid = 0; c_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("D%0d_flushed", i), c_out_valid, 0);
      tick();
    end

    // 64-bit decode through two stages
    for (int i = 0; i < 4; i++) begin
      c_in_valid = 1; c_inst = vc[i].inst; c_pc = vc[i].pc;
      tick();
      c_in_valid = 0;
      #1;
      check($sformatf("E%0d_lat", i), c_out_valid, 0);
      tick();
      check($sformatf("E%0d_valid", i), c_out_valid, 1);
      check($sformatf("E%0d_imm", i),   c_imm, vc[i].imm);
      check($sformatf("E%0d_type", i),  c_type, vc[i].typ);
      check($sformatf("E%0d_tgt", i),   c_tgt, vc[i].tgt);
      check($sformatf("E%0d_ill", i),   c_ill, vc[i].ill);
    end

    // asynchronous reset mid-stream
    b_out_ready = 0;
    b_in_valid = 1; b_inst = addi(40); b_pc = 32'h4000;
    tick();
    b_inst = addi(41); b_pc = 32'h4004;
    tick();
    b_in_valid = 0;
    tick();
    #1;
    check("R_valid_before", b_out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("R_valid_async", b_out_valid, 0);
    check("R_imm_async", b_imm, 0);
    check("R_tgt_async", b_tgt, 0);
    tick();
    rst = 1'b0;
    b_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("R%0d_after", i), b_out_valid, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
